sap_cpu_core: RTL and testbench
===============================

// Module: sap_cpu_core
// PURPOSE
//  Parametrised next-generation accumulator CPU: fetch/decode/execute core with embedded RAM,
//  A/B registers, registered carry/zero flags and conditional jumps. Multi-cycle microsequenced.
//  Program is loaded through a write port while held in reset. Results leave on a registered
//  output port with a one-cycle valid strobe. This is the top-level core of the teaching machine.
// PARAMETERS
//  DATA_W  8  data/instruction width; opcode = instr[DATA_W-1 -: 4], operand = instr[ADDR_W-1:0]
//  ADDR_W  4  address width; RAM depth = 2**ADDR_W words; DATA_W >= ADDR_W+4 is required
// PORTS
//  clk        in   1       single clock, all state updates on rising edge
//  rst        in   1       synchronous, active-high reset
//  prog_we    in   1       RAM program write strobe; honoured only while rst=1
//  prog_addr  in   ADDR_W  program write address
//  prog_data  in   DATA_W  program write data
//  out_data   out  DATA_W  output register (written by OUT)
//  out_valid  out  1       one-cycle pulse; out_data updated on the same edge
//  halted     out  1       high from HLT execute until rst
//  pc_dbg     out  ADDR_W  current program counter
// BEHAVIOUR
//  Reset: PC, MAR, IR, A, B, out_data, C, Z = 0; out_valid = 0; halted = 0; state = F0. RAM preserved.
//  rst has priority over all core activity: any in-flight instruction is aborted, no STA write.
//  prog_we with rst=1 writes RAM[prog_addr] <= prog_data; prog_we with rst=0 is ignored.
//  RAM: combinational read, synchronous write.
//  States: F0 MAR<=PC | F1 IR<=RAM[MAR], PC<=PC+1 (wraps 2**ADDR_W-1 -> 0) | E0 | E1 | E2 | HALT.
//  Opcodes (op = operand field, zero-extended where written to DATA_W registers):
//   0 NOP  E0 none                                     -> 3 cycles
//   1 LDA  E0 MAR<=op; E1 A<=RAM[MAR]                  -> 4
//   2 ADD  E0 MAR<=op; E1 B<=RAM[MAR]; E2 A<=A+B       -> 5
//   3 SUB  same as ADD, but E2 A<=A-B                  -> 5
//   4 STA  E0 MAR<=op; E1 RAM[MAR]<=A                  -> 4
//   5 LDI  E0 A<=op                                    -> 3
//   6 JMP  E0 PC<=op                                   -> 3
//   7 JC   E0 PC<=op if C                              -> 3
//   8 JZ   E0 PC<=op if Z                              -> 3
//   E OUT  E0 out_data<=A, out_valid<=1 for one cycle  -> 3
//   F HLT  E0 -> HALT; halted<=1; HALT is absorbing until rst
//   9-D    treated as NOP (3 cycles)
//  After the last microstep of an instruction the next state is F0.
//  Flags: updated only in E2 of ADD/SUB, from a DATA_W+1-bit result.
//   ADD: C = carry out. SUB is computed as A + ~B + 1, so C = 1 iff A >= B (no borrow).
//   Z = (DATA_W-bit result == 0). JC/JZ use the flags registered by earlier instructions.
//  Arithmetic wraps modulo 2**DATA_W. In HALT all registers hold and out_valid = 0.
// STRUCTURE
//  Package sap_cpu_pkg: opcode localparams (OP_NOP..OP_HLT), state encoding (F0,F1,E0,E1,E2,HALT).
//  One sub-module, sap_cpu_ram (param DATA_W, ADDR_W): 1 write port, 1 async read port.
//  Its write port is muxed: prog_* while rst=1, core STA otherwise.
//  Core, ALU and sequencer remain in sap_cpu_core.
// TESTING
//  1 Load {LDA 14, ADD 15, OUT, HLT}, RAM[14]=28, RAM[15]=14; release rst
//    -> out_valid single pulse after edge 12 with out_data=42; halted=1 after edge 15; pc_dbg=4.
//  2 Load {0:ADD 15, 1:OUT, 2:JC 4, 3:JMP 0, 4:HLT}, RAM[15]=1
//    -> 256 out_valid pulses with out_data 1..255 then 0; C=1 on last; halted.
//  3 Load {LDI 5, SUB 15, JZ 4, HLT, 4:OUT, HLT}, RAM[15]=5
//    -> JZ taken, out_data=0, C=1, Z=1. Same program with RAM[15]=6 -> halts at 3, no out_valid, C=0.
//  4 Load {LDI 9, STA 13, LDI 0, LDA 13, OUT, HLT}
//    -> out_data=9, RAM[13]=9. All-zero RAM (NOPs) -> pc_dbg 15 -> 0 wrap, new fetch every 3 cycles.
//  5 Assert rst during E1 of STA, and also during E2 of ADD
//    -> RAM target unchanged, all registers/flags 0, state F0, program intact, reruns identically.
//  6 Opcodes 9..D each -> 3-cycle NOP, no register, flag or RAM change; prog_we with rst=0 ignored.

Source files
------------

// File: rtl/sap_cpu_pkg.sv
// Shared opcode and microsequencer state encodings for the SAP accumulator core.
package sap_cpu_pkg;

  localparam logic [3:0] OP_NOP = 4'h0;
  localparam logic [3:0] OP_LDA = 4'h1;
  localparam logic [3:0] OP_ADD = 4'h2;
  localparam logic [3:0] OP_SUB = 4'h3;
  localparam logic [3:0] OP_STA = 4'h4;
  localparam logic [3:0] OP_LDI = 4'h5;
  localparam logic [3:0] OP_JMP = 4'h6;
  localparam logic [3:0] OP_JC  = 4'h7;
  localparam logic [3:0] OP_JZ  = 4'h8;
  localparam logic [3:0] OP_OUT = 4'hE;
  localparam logic [3:0] OP_HLT = 4'hF;

  localparam logic [2:0] ST_F0   = 3'd0;
  localparam logic [2:0] ST_F1   = 3'd1;
  localparam logic [2:0] ST_E0   = 3'd2;
  localparam logic [2:0] ST_E1   = 3'd3;
  localparam logic [2:0] ST_E2   = 3'd4;
  localparam logic [2:0] ST_HALT = 3'd5;

endpackage

// File: rtl/sap_cpu_ram.sv
// Single-port-write, async-read program/data RAM for the SAP core.
module sap_cpu_ram #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned ADDR_W = 4
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  localparam int unsigned DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/sap_cpu_core.sv
// Multi-cycle accumulator CPU: fetch/decode/execute sequencer, ALU, flags and embedded RAM.
module sap_cpu_core
  import sap_cpu_pkg::*;
#(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned ADDR_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              prog_we,
  input  logic [ADDR_W-1:0] prog_addr,
  input  logic [DATA_W-1:0] prog_data,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  output logic              halted,
  output logic [ADDR_W-1:0] pc_dbg
);

  localparam int unsigned RES_W = DATA_W + 1;

  logic [2:0]        state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d, mar_q, mar_d;
  logic [DATA_W-1:0] ir_q, ir_d, a_q, a_d, b_q, b_d, out_d;
  logic              c_q, c_d, z_q, z_d, valid_d, halted_d;
  logic              core_we;
  logic [DATA_W-1:0] rdata;
  logic [3:0]        opc;
  logic [ADDR_W-1:0] operand;
  logic [RES_W-1:0]  alu;
  logic [DATA_W-1:0] b_op;
  logic              sub;

  // Program port owns the RAM while in reset; core STA is locked out then.
  sap_cpu_ram #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_ram (
    .clk   (clk),
    .we    (rst ? prog_we : core_we),
    .waddr (rst ? prog_addr : mar_q),
    .wdata (rst ? prog_data : a_q),
    .raddr (mar_q),
    .rdata (rdata)
  );

  assign opc     = ir_q[DATA_W-1 -: 4];
  assign operand = ir_q[ADDR_W-1:0];
  assign pc_dbg  = pc_q;

  // SUB is A + ~B + 1 so the carry out doubles as "no borrow".
  always_comb begin
    sub  = (opc == OP_SUB);
    b_op = sub ? ~b_q : b_q;
    alu  = {1'b0, a_q} + {1'b0, b_op} + RES_W'(sub);
  end

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    mar_d    = mar_q;
    ir_d     = ir_q;
    a_d      = a_q;
    b_d      = b_q;
    c_d      = c_q;
    z_d      = z_q;
    out_d    = out_data;
    valid_d  = 1'b0;
    halted_d = halted;
    core_we  = 1'b0;
    case (state_q)
      ST_F0: begin
        mar_d   = pc_q;
        state_d = ST_F1;
      end
      ST_F1: begin
        ir_d    = rdata;
        pc_d    = pc_q + ADDR_W'(1);
        state_d = ST_E0;
      end
      ST_E0: begin
        state_d = ST_F0;
        case (opc)
          OP_LDA, OP_ADD, OP_SUB, OP_STA: begin
            mar_d   = operand;
            state_d = ST_E1;
          end
          OP_LDI: a_d = DATA_W'(operand);
          OP_JMP: pc_d = operand;
          OP_JC:  if (c_q) pc_d = operand;
          OP_JZ:  if (z_q) pc_d = operand;
          OP_OUT: begin
            out_d   = a_q;
            valid_d = 1'b1;
          end
          OP_HLT: begin
            state_d  = ST_HALT;
            halted_d = 1'b1;
          end
          default: ;
        endcase
      end
      ST_E1: begin
        state_d = ST_F0;
        case (opc)
          OP_LDA: a_d = rdata;
          OP_ADD, OP_SUB: begin
            b_d     = rdata;
            state_d = ST_E2;
          end
          OP_STA: core_we = 1'b1;
          default: ;
        endcase
      end
      ST_E2: begin
        a_d     = alu[DATA_W-1:0];
        c_d     = alu[DATA_W];
        z_d     = (alu[DATA_W-1:0] == '0);
        state_d = ST_F0;
      end
      ST_HALT: state_d = ST_HALT;
      default: state_d = ST_F0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_F0;
      pc_q      <= '0;
      mar_q     <= '0;
      ir_q      <= '0;
      a_q       <= '0;
      b_q       <= '0;
      c_q       <= 1'b0;
      z_q       <= 1'b0;
      out_data  <= '0;
      out_valid <= 1'b0;
      halted    <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      mar_q     <= mar_d;
      ir_q      <= ir_d;
      a_q       <= a_d;
      b_q       <= b_d;
      c_q       <= c_d;
      z_q       <= z_d;
      out_data  <= out_d;
      out_valid <= valid_d;
      halted    <= halted_d;
    end
  end

endmodule

// File: tb/tb_sap_cpu_core.sv
// Directed self-checking bench for sap_cpu_core with hand-computed program results.
module tb_sap_cpu_core;
  import sap_cpu_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic       prog_we;
  logic [3:0] prog_addr;
  logic [7:0] prog_data;
  logic [7:0] out_data;
  logic       out_valid;
  logic       halted;
  logic [3:0] pc_dbg;

  sap_cpu_core #(.DATA_W(8), .ADDR_W(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .prog_we   (prog_we),
    .prog_addr (prog_addr),
    .prog_data (prog_data),
    .out_data  (out_data),
    .out_valid (out_valid),
    .halted    (halted),
    .pc_dbg    (pc_dbg)
  );

  always #5 clk = ~clk;

  int         n_tests = 0;
  int         n_fail  = 0;
  int         edge_n;
  int         out_edge;
  int         halt_edge;
  logic [7:0] prog [16];
  logic [7:0] out_q [$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic clr_prog();
    for (int i = 0; i < 16; i++) prog[i] = 8'h00;
  endtask

  // Hold reset and write every RAM word from prog[].
  task automatic load();
    rst = 1'b1;
    for (int i = 0; i < 16; i++) begin
      prog_addr = 4'(i);
      prog_data = prog[i];
      prog_we   = 1'b1;
      @(posedge clk); #1;
    end
    prog_we = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic release_rst();
    rst       = 1'b0;
    edge_n    = 0;
    out_edge  = -1;
    halt_edge = -1;
    out_q.delete();
  endtask

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      edge_n++;
      if (out_valid) begin
        out_q.push_back(out_data);
        if (out_edge < 0) out_edge = edge_n;
      end
      if (halted && halt_edge < 0) halt_edge = edge_n;
    end
  endtask

  task automatic run_to_halt(input int max);
    while (!halted && edge_n < max) step(1);
    if (!halted) check("halt_timeout", 32'd0, 32'd1);
  endtask

  function automatic logic [7:0] out_at(input int i);
    return (i < out_q.size()) ? out_q[i] : 8'hXX;
  endfunction

  initial begin
    rst = 1'b1; prog_we = 1'b0; prog_addr = '0; prog_data = '0;

    // 1: LDA 14, ADD 15, OUT, HLT
    clr_prog();
    prog[0] = 8'h1E; prog[1] = 8'h2F; prog[2] = 8'hE0; prog[3] = 8'hF0;
    prog[14] = 8'd28; prog[15] = 8'd14;
    load();
    check("rst_pc", 32'(pc_dbg), 32'd0);
    check("rst_valid", 32'(out_valid), 32'd0);
    check("rst_halted", 32'(halted), 32'd0);
    check("rst_out", 32'(out_data), 32'd0);
    release_rst();
    run_to_halt(100);
    check("t1_nout", out_q.size(), 32'd1);
    check("t1_out_edge", 32'(out_edge), 32'd12);
    check("t1_out", 32'(out_at(0)), 32'd42);
    check("t1_halt_edge", 32'(halt_edge), 32'd15);
    check("t1_pc", 32'(pc_dbg), 32'd4);
    step(3);
    check("t1_hold_pc", 32'(pc_dbg), 32'd4);
    check("t1_hold_valid", 32'(out_valid), 32'd0);

    // 5b: reset during E2 of ADD aborts the add
    load();
    release_rst();
    step(8);
    check("t5b_in_e2", 32'(dut.state_q), 32'(ST_E2));
    rst = 1'b1;
    step(1);
    check("t5b_a", 32'(dut.a_q), 32'd0);
    check("t5b_b", 32'(dut.b_q), 32'd0);
    check("t5b_state", 32'(dut.state_q), 32'(ST_F0));
    check("t5b_pc", 32'(pc_dbg), 32'd0);
    check("t5b_prog", 32'(dut.u_ram.mem[0]), 32'h1E);
    release_rst();
    run_to_halt(100);
    check("t5b_rerun_edge", 32'(out_edge), 32'd12);
    check("t5b_rerun_out", 32'(out_at(0)), 32'd42);

    // 2: count 1..255,0 using carry to exit
    clr_prog();
    prog[0] = 8'h2F; prog[1] = 8'hE0; prog[2] = 8'h74; prog[3] = 8'h60; prog[4] = 8'hF0;
    prog[15] = 8'd1;
    load();
    release_rst();
    run_to_halt(5000);
    check("t2_nout", out_q.size(), 32'd256);
    check("t2_first", 32'(out_at(0)), 32'd1);
    check("t2_255", 32'(out_at(254)), 32'd255);
    check("t2_last", 32'(out_at(255)), 32'd0);
    check("t2_c", 32'(dut.c_q), 32'd1);
    check("t2_pc", 32'(pc_dbg), 32'd5);

    // 3: SUB to zero, JZ taken
    clr_prog();
    prog[0] = 8'h55; prog[1] = 8'h3F; prog[2] = 8'h84; prog[3] = 8'hF0;
    prog[4] = 8'hE0; prog[5] = 8'hF0; prog[15] = 8'd5;
    load();
    release_rst();
    run_to_halt(200);
    check("t3a_nout", out_q.size(), 32'd1);
    check("t3a_out", 32'(out_at(0)), 32'd0);
    check("t3a_c", 32'(dut.c_q), 32'd1);
    check("t3a_z", 32'(dut.z_q), 32'd1);
    check("t3a_pc", 32'(pc_dbg), 32'd6);
    prog[15] = 8'd6;
    load();
    release_rst();
    run_to_halt(200);
    check("t3b_nout", out_q.size(), 32'd0);
    check("t3b_c", 32'(dut.c_q), 32'd0);
    check("t3b_z", 32'(dut.z_q), 32'd0);
    check("t3b_a", 32'(dut.a_q), 32'd255);
    check("t3b_pc", 32'(pc_dbg), 32'd4);

    // 4: STA/LDA round trip
    clr_prog();
    prog[0] = 8'h59; prog[1] = 8'h4D; prog[2] = 8'h50; prog[3] = 8'h1D;
    prog[4] = 8'hE0; prog[5] = 8'hF0;
    load();
    release_rst();
    run_to_halt(200);
    check("t4_out", 32'(out_at(0)), 32'd9);
    check("t4_ram13", 32'(dut.u_ram.mem[13]), 32'd9);

    // 5a: reset during E1 of STA suppresses the write
    load();
    release_rst();
    step(6);
    check("t5a_in_e1", 32'(dut.state_q), 32'(ST_E1));
    rst = 1'b1;
    step(1);
    check("t5a_ram13", 32'(dut.u_ram.mem[13]), 32'd0);
    check("t5a_a", 32'(dut.a_q), 32'd0);
    check("t5a_mar", 32'(dut.mar_q), 32'd0);
    check("t5a_state", 32'(dut.state_q), 32'(ST_F0));
    release_rst();
    run_to_halt(200);
    check("t5a_rerun_out", 32'(out_at(0)), 32'd9);

    // 4b: all-NOP RAM, PC wraps 15 -> 0
    clr_prog();
    load();
    release_rst();
    step(44);
    check("t4b_pc15", 32'(pc_dbg), 32'd15);
    step(2);
    check("t4b_pc15_hold", 32'(pc_dbg), 32'd15);
    step(1);
    check("t4b_pc_wrap", 32'(pc_dbg), 32'd0);
    step(3);
    check("t4b_pc1", 32'(pc_dbg), 32'd1);

    // 6: opcodes 9..D behave as NOP; prog_we ignored while running
    clr_prog();
    prog[0] = 8'h57; prog[1] = 8'h9D; prog[2] = 8'hAD; prog[3] = 8'hBD;
    prog[4] = 8'hCD; prog[5] = 8'hDD; prog[6] = 8'hE0; prog[7] = 8'hF0;
    prog[13] = 8'h33;
    load();
    release_rst();
    prog_we = 1'b1; prog_addr = 4'd13; prog_data = 8'hAA;
    run_to_halt(200);
    prog_we = 1'b0;
    check("t6_out_edge", 32'(out_edge), 32'd21);
    check("t6_out", 32'(out_at(0)), 32'd7);
    check("t6_b", 32'(dut.b_q), 32'd0);
    check("t6_flags", {30'd0, dut.c_q, dut.z_q}, 32'd0);
    check("t6_ram13", 32'(dut.u_ram.mem[13]), 32'h33);
    check("t6_halt_edge", 32'(halt_edge), 32'd24);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
